// File: rtl/mem_pkg.sv
// Shared types and constants for the CPU/DMA memory arbiter.
package mem_pkg;
  localparam int ADDR_W = 20;
  localparam int DATA_W = 8;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] out;
    logic              wren;
  } req_t;
endpackage

// File: rtl/mem_arbiter.sv
// Serialises CPU and DMA byte accesses onto one synchronous RAM bus.
// Fixed 4-cycle access (IDLE, ACC, WAIT, RESP); DMA bursts bounded so the CPU is never starved.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int DMA_BURST = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_out,
  input  logic              cpu_wren,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_data,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_address,
  input  logic [DATA_W-1:0] dma_out,
  input  logic              dma_wren,
  output logic              dma_ready,
  output logic [DATA_W-1:0] dma_data,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_out,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_data
);
  state_t     state, state_nxt;
  logic       owner;
  logic       wren_q;
  logic [3:0] burst_cnt;
  logic       grant;
  logic       cpu_wins;
  req_t       win;

  // CPU wins when DMA is absent or has used up its burst allowance.
  always_comb begin
    cpu_wins = cpu_req && (!dma_req || (burst_cnt == 4'(DMA_BURST)));
    grant    = (state == IDLE) && (cpu_req || dma_req);
    if (cpu_wins) begin
      win.address = cpu_address;
      win.out     = cpu_out;
      win.wren    = cpu_wren;
    end else begin
      win.address = dma_address;
      win.out     = dma_out;
      win.wren    = dma_wren;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cpu_req || dma_req) state_nxt = ACC;
      ACC:     state_nxt = WAIT;
      WAIT:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_address <= '0;
      mem_out     <= '0;
      mem_wren    <= 1'b0;
      cpu_ready   <= 1'b0;
      dma_ready   <= 1'b0;
      cpu_data    <= '0;
      dma_data    <= '0;
      owner       <= OWN_CPU;
      wren_q      <= 1'b0;
      burst_cnt   <= '0;
    end else begin
      cpu_ready <= 1'b0;
      dma_ready <= 1'b0;
      mem_wren  <= 1'b0;
      if (grant) begin
        mem_address <= win.address;
        mem_out     <= win.out;
        mem_wren    <= win.wren;
        wren_q      <= win.wren;
        owner       <= cpu_wins ? OWN_CPU : OWN_DMA;
        if (cpu_wins)     burst_cnt <= '0;
        else if (cpu_req) burst_cnt <= burst_cnt + 4'd1;
      end
      // RAM read data is valid during WAIT; writes keep the previous read value.
      if (state == WAIT) begin
        if (owner == OWN_CPU) begin
          cpu_ready <= 1'b1;
          if (!wren_q) cpu_data <= mem_data;
        end else begin
          dma_ready <= 1'b1;
          if (!wren_q) dma_data <= mem_data;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, multi-cycle corner cases, randomized traffic vs reference model.
module tb_mem_arbiter;
  import mem_pkg::*;
  localparam int DMA_BURST = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_wren = 1'b0, cpu_ready;
  logic [19:0] cpu_address = '0;
  logic [7:0]  cpu_out = '0, cpu_data;
  logic        dma_req = 1'b0, dma_wren = 1'b0, dma_ready;
  logic [19:0] dma_address = '0;
  logic [7:0]  dma_out = '0, dma_data;
  logic [19:0] mem_address;
  logic [7:0]  mem_out, mem_data;
  logic        mem_wren;

  mem_arbiter #(.DMA_BURST(DMA_BURST)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_address(cpu_address), .cpu_out(cpu_out), .cpu_wren(cpu_wren),
    .cpu_ready(cpu_ready), .cpu_data(cpu_data),
    .dma_req(dma_req), .dma_address(dma_address), .dma_out(dma_out), .dma_wren(dma_wren),
    .dma_ready(dma_ready), .dma_data(dma_data),
    .mem_address(mem_address), .mem_out(mem_out), .mem_wren(mem_wren), .mem_data(mem_data)
  );

  always #5 clock = ~clock;

  // Synchronous RAM with a bench-side preload port.
  bit   [7:0]  ram [0:1048575];
  logic        pre_we = 1'b0;
  logic [19:0] pre_addr = '0;
  logic [7:0]  pre_data = '0;
  always @(posedge clock) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (mem_wren) ram[mem_address] <= mem_out;
    mem_data <= ram[mem_address];
  end

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  // Reference model: one transaction in flight, tracked by cycles since its grant.
  bit   [7:0]  ref_mem [0:1048575];
  bit          mdl_on = 1'b0;
  int          age = 0;
  int          cnt = 0;
  bit          m_own, m_wren;
  logic [19:0] m_addr;
  logic [7:0]  m_wdata, m_rd, e_cpu, e_dma;

  logic        s_cpu_ready, s_dma_ready, s_mem_wren;
  logic [7:0]  s_cpu_data, s_dma_data, s_mem_out;
  logic [19:0] s_mem_address;

  task automatic tick();
    bit cw;
    @(posedge clock);
    if (!mdl_on || reset) begin
      age = 0; cnt = 0; e_cpu = '0; e_dma = '0;
    end else if (age == 0) begin
      if (cpu_req || dma_req) begin
        cw = cpu_req && (!dma_req || cnt == DMA_BURST);
        if (cw) begin
          m_own = 1'b0; m_addr = cpu_address; m_wdata = cpu_out; m_wren = cpu_wren; cnt = 0;
        end else begin
          m_own = 1'b1; m_addr = dma_address; m_wdata = dma_out; m_wren = dma_wren;
          if (cpu_req) cnt++;
        end
        if (m_wren) ref_mem[m_addr] = m_wdata;
        else        m_rd = ref_mem[m_addr];
        age = 1;
      end
    end else if (age == 3) begin
      age = 0;
    end else begin
      age++;
      if (age == 3 && !m_wren) begin
        if (m_own) e_dma = m_rd;
        else       e_cpu = m_rd;
      end
    end
    #1;
    s_cpu_ready = cpu_ready; s_dma_ready = dma_ready; s_mem_wren = mem_wren;
    s_cpu_data = cpu_data; s_dma_data = dma_data; s_mem_out = mem_out; s_mem_address = mem_address;
    if (mdl_on && !reset) begin
      chk("mdl_cpu_ready", cpu_ready, (age == 3 && !m_own));
      chk("mdl_dma_ready", dma_ready, (age == 3 && m_own));
      chk("mdl_mem_wren", mem_wren, (age == 1 && m_wren));
      chk("mdl_cpu_data", cpu_data, e_cpu);
      chk("mdl_dma_data", dma_data, e_dma);
      if (age != 0) chk("mdl_mem_address", mem_address, m_addr);
      if (age == 1 && m_wren) chk("mdl_mem_out", mem_out, m_wdata);
    end
    @(negedge clock);
  endtask

  // One access from idle; leaves the arbiter back in IDLE.
  task automatic access(input bit dma, input bit wren, input logic [19:0] addr, input logic [7:0] wdata,
                        output int lat, output logic [7:0] rd, output int wpulse, output int other,
                        output logic [19:0] a1, output logic [7:0] o1);
    lat = 0; rd = '0; wpulse = 0; other = 0; a1 = '0; o1 = '0;
    if (dma) begin dma_req = 1; dma_address = addr; dma_wren = wren; dma_out = wdata; end
    else     begin cpu_req = 1; cpu_address = addr; cpu_wren = wren; cpu_out = wdata; end
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (s_mem_wren) wpulse++;
      if (i == 1) begin a1 = s_mem_address; o1 = s_mem_out; end
      if (dma ? s_cpu_ready : s_dma_ready) other++;
      if (dma ? s_dma_ready : s_cpu_ready) begin
        lat = i; rd = dma ? s_dma_data : s_cpu_data;
        break;
      end
    end
    cpu_req = 0; dma_req = 0;
    tick();
  endtask

  typedef struct {
    bit          dma;
    bit          wren;
    logic [19:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rd;
  } vec_t;

  initial begin
    vec_t        vecs [9];
    int          lat, wp, oth, ncpu, ndma, ng;
    logic [7:0]  rd, o1;
    logic [19:0] a1;
    logic [31:0] cmask, dmask;
    bit          c_act, d_act;
    bit          owners [$];

    vecs[0] = '{0, 0, 20'h12345, 8'h00, 8'hA5};
    vecs[1] = '{0, 1, 20'h00400, 8'h3C, 8'hA5};
    vecs[2] = '{0, 0, 20'h00400, 8'h00, 8'h3C};
    vecs[3] = '{1, 1, 20'hFFFFF, 8'h5A, 8'h00};
    vecs[4] = '{1, 0, 20'hFFFFF, 8'h00, 8'h5A};
    vecs[5] = '{1, 0, 20'h00400, 8'h00, 8'h3C};
    vecs[6] = '{0, 1, 20'h00000, 8'hFF, 8'h3C};
    vecs[7] = '{1, 0, 20'h00000, 8'h00, 8'hFF};
    vecs[8] = '{0, 0, 20'h00000, 8'h00, 8'hFF};

    @(negedge clock);
    pre_we = 1; pre_addr = 20'h12345; pre_data = 8'hA5;
    ref_mem[20'h12345] = 8'hA5;
    @(negedge clock);
    pre_we = 0;
    chk("rst_mem_address", mem_address, 20'h0);
    chk("rst_mem_out", mem_out, 8'h0);
    chk("rst_mem_wren", mem_wren, 1'b0);
    chk("rst_cpu_ready", cpu_ready, 1'b0);
    chk("rst_dma_ready", dma_ready, 1'b0);
    chk("rst_cpu_data", cpu_data, 8'h0);
    chk("rst_dma_data", dma_data, 8'h0);
    reset = 0; mdl_on = 1;
    tick();

    for (int v = 0; v < 9; v++) begin
      access(vecs[v].dma, vecs[v].wren, vecs[v].addr, vecs[v].wdata, lat, rd, wp, oth, a1, o1);
      chk($sformatf("vec%0d_latency", v), lat, 3);
      chk($sformatf("vec%0d_data", v), rd, vecs[v].exp_rd);
      chk($sformatf("vec%0d_wren_pulses", v), wp, vecs[v].wren);
      chk($sformatf("vec%0d_other_ready", v), oth, 0);
      chk($sformatf("vec%0d_addr", v), a1, vecs[v].addr);
      if (vecs[v].wren) chk($sformatf("vec%0d_mem_out", v), o1, vecs[v].wdata);
    end

    // CPU back-to-back reads; DMA request arriving mid-access waits for IDLE and then wins.
    cmask = '0; dmask = '0;
    cpu_req = 1; cpu_address = 20'h00400; cpu_wren = 0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (s_cpu_ready) cmask[t] = 1'b1;
      if (s_dma_ready) dmask[t] = 1'b1;
      if (t == 6) begin dma_req = 1; dma_address = 20'h12345; dma_wren = 0; end
    end
    cpu_req = 0; dma_req = 0;
    tick();
    chk("b2b_cpu_ready_cycles", cmask, 32'h0000_0088);
    chk("b2b_dma_ready_cycles", dmask, 32'h0000_0800);

    // CPU drops req during WAIT: access still completes, exactly once.
    cpu_req = 1; cpu_address = 20'h12345; cpu_wren = 0;
    tick(); tick();
    cpu_req = 0;
    ncpu = 0;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (s_cpu_ready) ncpu++;
    end
    chk("drop_wait_cpu_pulses", ncpu, 1);
    chk("drop_wait_cpu_data", s_cpu_data, 8'hA5);

    // Contention from a fresh reset: DMA x DMA_BURST then CPU, repeating.
    mdl_on = 0; reset = 1;
    tick();
    reset = 0; mdl_on = 1;
    cpu_req = 1; cpu_address = 20'h00400; cpu_wren = 0;
    dma_req = 1; dma_address = 20'hFFFFF; dma_wren = 0;
    owners.delete();
    for (int t = 0; t < 60 && owners.size() < 10; t++) begin
      tick();
      if (s_cpu_ready) owners.push_back(1'b0);
      if (s_dma_ready) owners.push_back(1'b1);
    end
    cpu_req = 0; dma_req = 0;
    tick();
    chk("contend_grants", owners.size(), 10);
    for (int k = 0; k < owners.size(); k++)
      chk($sformatf("contend_owner%0d", k), owners[k], (k % 5 != 4));

    // Reset during ACC of a DMA write: abandoned at once, nothing left behind.
    dma_req = 1; dma_address = 20'hABCDE; dma_wren = 1; dma_out = 8'h77;
    tick();
    chk("rstacc_wren_before", s_mem_wren, 1'b1);
    mdl_on = 0; reset = 1;
    #1;
    chk("rstacc_mem_wren", mem_wren, 1'b0);
    chk("rstacc_mem_address", mem_address, 20'h0);
    chk("rstacc_mem_out", mem_out, 8'h0);
    chk("rstacc_dma_ready", dma_ready, 1'b0);
    chk("rstacc_cpu_data", cpu_data, 8'h0);
    chk("rstacc_dma_data", dma_data, 8'h0);
    dma_req = 0;
    tick(); tick();
    reset = 0; mdl_on = 1;
    ndma = 0;
    for (int t = 0; t < 6; t++) begin
      tick();
      if (s_dma_ready) ndma++;
    end
    chk("rstacc_no_dma_ready", ndma, 0);
    chk("rstacc_written", ram[20'hABCDE], 8'h00);
    access(0, 0, 20'h00400, 8'h00, lat, rd, wp, oth, a1, o1);
    chk("rstacc_idle_latency", lat, 3);
    chk("rstacc_idle_data", rd, 8'h3C);

    // Randomized traffic from two handshake agents over a small shared address window.
    c_act = 0; d_act = 0; ng = 0;
    for (int t = 0; t < 1500; t++) begin
      if (c_act && s_cpu_ready) begin c_act = 0; cpu_req = 0; ng++; end
      if (d_act && s_dma_ready) begin d_act = 0; dma_req = 0; ng++; end
      if (!c_act && $urandom_range(0, 2) == 0) begin
        c_act = 1; cpu_req = 1; cpu_address = 20'($urandom_range(0, 15));
        cpu_wren = 1'($urandom); cpu_out = 8'($urandom);
      end
      if (!d_act && $urandom_range(0, 1) == 0) begin
        d_act = 1; dma_req = 1; dma_address = 20'($urandom_range(0, 15));
        dma_wren = 1'($urandom); dma_out = 8'($urandom);
      end
      tick();
    end
    cpu_req = 0; dma_req = 0;
    for (int t = 0; t < 4; t++) tick();
    chk("rand_progress", (ng > 100), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single 20-bit-address, byte-wide memory bus between the 8-bit x86 `core` and a DMA/video fetch requester. It sits between both masters and the system RAM. It serialises their byte accesses with a req/ready handshake and bounds DMA bursts so the CPU is never starved. Each requester sees a fixed-latency read or write; the memory sees at most one access in flight.

## Interface
- `DMA_BURST`, default 4: max consecutive DMA grants while `cpu_req` is pending (1..15).
- `clock`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high.
- `cpu_req`  in  1  CPU access request; held with stable address/data/wren until `cpu_ready`.
- `cpu_address`  in  20  CPU byte address.
- `cpu_out`  in  8  CPU write data.
- `cpu_wren`  in  1  1 = write, 0 = read.
- `cpu_ready`  out  1  one-cycle completion pulse.
- `cpu_data`  out  8  read data; valid while `cpu_ready`=1, held until next CPU read completes.
- `dma_req`, `dma_address`, `dma_out`, `dma_wren`, `dma_ready`, `dma_data`: same directions and widths as the CPU port.
- `mem_address`  out  20  RAM address.
- `mem_out`  out  8  RAM write data.
- `mem_wren`  out  1  RAM write strobe.
- `mem_data`  in  8  RAM read data; synchronous RAM, valid the cycle after the address edge.

## Operation
- FSM states: IDLE, ACC, WAIT, RESP. Every access runs IDLE→ACC→WAIT→RESP→IDLE.
- IDLE: requests are sampled only here. If neither is pending, stay in IDLE. Otherwise pick a winner and latch its address, out, wren and an `owner` bit, then go to ACC.
- Winner selection:
  - DMA wins by default.
  - CPU wins if `cpu_req`=1 and `burst_cnt`==`DMA_BURST`.
  - CPU wins if `dma_req`=0.
- `burst_cnt`: incremented on each DMA grant made while `cpu_req`=1. Cleared on any CPU grant. Never exceeds `DMA_BURST`.
- ACC: drive the latched address. `mem_wren` = latched wren for this cycle only. `mem_out` = latched data.
- WAIT: address held, `mem_wren`=0. At the closing edge:
  - capture `mem_data` into the owner's data register, reads only; writes leave the data register unchanged;
  - set the owner's ready.
- RESP: owner's ready=1 for exactly this cycle. Then go to IDLE.
- The requester drops or changes `req` on the edge ending RESP. A `req` still high in the following IDLE is treated as a new access.
- A requester dropping `req` mid-access does not abort: the access completes and ready still pulses.
- Only one of `cpu_ready`/`dma_ready` is ever high; never both.

## Timing
- Reset values:
  - `mem_address`=0, `mem_out`=0, `mem_wren`=0;
  - `cpu_ready`=`dma_ready`=0, `cpu_data`=`dma_data`=0;
  - state IDLE, `burst_cnt`=0, `owner`=0.
- All outputs are registered; no combinational req→ready path.
- Request sampled at edge E0 (IDLE). Memory address and strobe are driven during E0–E1. Ready is high during E2–E3.
- Latency is 3 cycles. Throughput is one access per 4 cycles.
- Reset asserted mid-access: access abandoned immediately, no ready pulse, `mem_wren` drops asynchronously.
- Simultaneous requests with `burst_cnt`<`DMA_BURST`: DMA is granted. The CPU is served no later than after `DMA_BURST` DMA accesses.

## Structure
- Shared package `mem_pkg`: state encoding (IDLE=0, ACC=1, WAIT=2, RESP=3), owner constants `OWN_CPU`=0 and `OWN_DMA`=1, address width 20, data width 8.
- No sub-module; a single FSM plus burst counter.

## Test plan
- CPU read alone: RAM[0x12345]=0xA5, `cpu_req` pulsed at E0 with wren=0 → `mem_address`=0x12345 from E0; `cpu_ready`=1 and `cpu_data`=0xA5 exactly in cycle E2–E3; `dma_ready` stays 0.
- CPU write: address 0x00400, `cpu_out`=0x3C → `mem_wren`=1 for exactly one cycle with `mem_out`=0x3C; a subsequent read returns 0x3C.
- Contention with `DMA_BURST`=4, both requests held continuously → grant order DMA,DMA,DMA,DMA,CPU, repeating; `burst_cnt` never exceeds 4.
- `dma_req` idle, CPU back-to-back reads → one `cpu_ready` pulse every 4 cycles; DMA request arriving mid-access waits for IDLE.
- Reset asserted during ACC of a DMA write → `mem_wren`=0 immediately, no `dma_ready`, all outputs 0, FSM in IDLE after release.
- `cpu_req` dropped during WAIT → `cpu_ready` still pulses once; no second access.
